// File: rtl/burst_mem_pkg.sv
// Shared types and constants for the burst memory responder.
package burst_mem_pkg;

  localparam int unsigned LINE_WIDTH       = 256;
  localparam int unsigned LINE_OFFSET_BITS = 5;
  localparam int unsigned BEATS_PER_LINE   = LINE_WIDTH / 64;

  typedef logic [$clog2(BEATS_PER_LINE)-1:0] beat_idx_t;

  typedef enum logic [2:0] {
    StIdle,
    StRLat,
    StRBurst,
    StWLat,
    StWBurst,
    StDone
  } bm_state_e;

endpackage

// File: rtl/burst_mem_array.sv
// Line-addressed beat storage: one beat-granular write port, one registered read port.
// The read register returns zero on cycles without a read enable; storage itself is never reset.
module burst_mem_array
  import burst_mem_pkg::*;
#(
  parameter int unsigned DEPTH_LINES = 256,
  parameter int unsigned BEATS       = 4,
  parameter int unsigned BEAT_WIDTH  = 64
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [$clog2(DEPTH_LINES)-1:0] idx_i,
  input  beat_idx_t                      beat_i,
  input  logic                           we_i,
  input  logic [BEAT_WIDTH-1:0]          wdata_i,
  input  logic                           re_i,
  output logic [BEAT_WIDTH-1:0]          rdata_o
);

  localparam int unsigned AddrW = $clog2(DEPTH_LINES) + $bits(beat_idx_t);

  logic [BEAT_WIDTH-1:0] mem_q [DEPTH_LINES*BEATS];
  logic [BEAT_WIDTH-1:0] rdata_q;
  logic [AddrW-1:0]      addr;

  assign addr = {idx_i, beat_i};

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr] <= wdata_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= re_i ? mem_q[addr] : '0;
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/burst_mem_responder.sv
// Cache-line burst memory responder: latency phase, then BEATS beats per line, then one DONE cycle.
// Optional BURST_MEM_STATS_EN adds rd_lines/wr_lines completed-burst counters.
module burst_mem_responder
  import burst_mem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH    = 32,
  parameter int unsigned BEAT_WIDTH    = 64,
  parameter int unsigned BEATS         = 4,
  parameter int unsigned DEPTH_LINES   = 256,
  parameter int unsigned READ_LATENCY  = 4,
  parameter int unsigned WRITE_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [ADDR_WIDTH-1:0] mem_address,
  input  logic [BEAT_WIDTH-1:0] mem_wdata,
  output logic [BEAT_WIDTH-1:0] mem_rdata,
  output logic                  mem_resp,
  output logic                  proto_err
`ifdef BURST_MEM_STATS_EN
  ,
  output logic [31:0]           rd_lines,
  output logic [31:0]           wr_lines
`endif
);

  localparam int unsigned IdxW     = $clog2(DEPTH_LINES);
  localparam beat_idx_t   LastBeat = beat_idx_t'(BEATS - 1);

  bm_state_e       state_q, state_d;
  logic [3:0]      lat_q, lat_d;
  beat_idx_t       beat_q, beat_d;
  logic [IdxW-1:0] idx_q, idx_d, addr_idx;
  logic            err_q, err_d;
  logic            resp_q, resp_d;
  logic            arr_re, arr_we;
  beat_idx_t       arr_beat;
  logic            unused_addr;

  assign addr_idx    = mem_address[LINE_OFFSET_BITS +: IdxW];
  assign unused_addr = ^mem_address;

  always_comb begin
    state_d  = state_q;
    lat_d    = lat_q;
    beat_d   = beat_q;
    idx_d    = idx_q;
    err_d    = err_q;
    arr_re   = 1'b0;
    arr_we   = 1'b0;
    arr_beat = beat_q;
    unique case (state_q)
      StIdle: begin
        if (mem_read) begin
          idx_d   = addr_idx;
          lat_d   = 4'(READ_LATENCY - 1);
          state_d = StRLat;
          if (mem_write) begin
            err_d = 1'b1;
          end
        end else if (mem_write) begin
          idx_d   = addr_idx;
          lat_d   = 4'(WRITE_LATENCY - 1);
          state_d = StWLat;
        end
      end
      StRLat: begin
        if (!mem_read) begin
          state_d = StIdle;
        end else if (lat_q == 4'd0) begin
          // Prefetch beat 0 so the registered read port is valid on the first burst cycle.
          state_d  = StRBurst;
          beat_d   = '0;
          arr_re   = 1'b1;
          arr_beat = '0;
        end else begin
          lat_d = lat_q - 4'd1;
        end
      end
      StRBurst: begin
        if (!mem_read) begin
          err_d = 1'b1;
        end
        if (beat_q == LastBeat) begin
          state_d = StDone;
        end else begin
          beat_d   = beat_q + 1'b1;
          arr_re   = 1'b1;
          arr_beat = beat_q + 1'b1;
        end
      end
      StWLat: begin
        if (!mem_write) begin
          state_d = StIdle;
        end else if (lat_q == 4'd0) begin
          state_d = StWBurst;
          beat_d  = '0;
        end else begin
          lat_d = lat_q - 4'd1;
        end
      end
      StWBurst: begin
        arr_we = 1'b1;
        if (!mem_write) begin
          err_d = 1'b1;
        end
        if (beat_q == LastBeat) begin
          state_d = StDone;
        end else begin
          beat_d = beat_q + 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign resp_d = (state_d == StRBurst) || (state_d == StWBurst);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      lat_q   <= '0;
      beat_q  <= '0;
      idx_q   <= '0;
      err_q   <= 1'b0;
      resp_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
      beat_q  <= beat_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
      resp_q  <= resp_d;
    end
  end

  burst_mem_array #(
    .DEPTH_LINES (DEPTH_LINES),
    .BEATS       (BEATS),
    .BEAT_WIDTH  (BEAT_WIDTH)
  ) u_array (
    .clk_i   (clk),
    .rst_i   (rst),
    .idx_i   (idx_q),
    .beat_i  (arr_beat),
    .we_i    (arr_we),
    .wdata_i (mem_wdata),
    .re_i    (arr_re),
    .rdata_o (mem_rdata)
  );

  assign mem_resp  = resp_q;
  assign proto_err = err_q;

`ifdef BURST_MEM_STATS_EN
  logic [31:0] rd_lines_q, wr_lines_q;

  // Count on the transition into DONE so aborted latency-phase requests never count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_lines_q <= '0;
      wr_lines_q <= '0;
    end else begin
      if (state_q == StRBurst && state_d == StDone) begin
        rd_lines_q <= rd_lines_q + 32'd1;
      end
      if (state_q == StWBurst && state_d == StDone) begin
        wr_lines_q <= wr_lines_q + 32'd1;
      end
    end
  end

  assign rd_lines = rd_lines_q;
  assign wr_lines = wr_lines_q;
`endif

endmodule

// File: tb/tb_burst_mem_responder.sv
// Directed bench for burst_mem_responder (default parameters; stats checks when BURST_MEM_STATS_EN).
module tb_burst_mem_responder;

  logic        clk;
  logic        rst;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_address;
  logic [63:0] mem_wdata;
  logic [63:0] mem_rdata;
  logic        mem_resp;
  logic        proto_err;
`ifdef BURST_MEM_STATS_EN
  logic [31:0] rd_lines;
  logic [31:0] wr_lines;
`endif

  int n_checks = 0;
  int n_errors = 0;

  burst_mem_responder dut (
    .clk         (clk),
    .rst         (rst),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .mem_address (mem_address),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .mem_resp    (mem_resp),
    .proto_err   (proto_err)
`ifdef BURST_MEM_STATS_EN
    ,
    .rd_lines    (rd_lines),
    .wr_lines    (wr_lines)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge of the DONE cycle with requests dropped.
  task automatic burst(input logic wr, input logic [31:0] addr, input logic [63:0] wb [4],
                       output logic [63:0] rb [4], output int first);
    int k;
    mem_address = addr;
    mem_wdata   = wb[0];
    if (wr) mem_write = 1'b1;
    else    mem_read  = 1'b1;
    k = 0;
    while (k < 40 && mem_resp !== 1'b1) begin
      @(posedge clk);
      k++;
      @(negedge clk);
    end
    first = (mem_resp === 1'b1) ? k : -1;
    for (int b = 0; b < 4; b++) begin
      check("resp_beat", 64'(mem_resp), 64'd1);
      rb[b] = mem_rdata;
      @(posedge clk);
      @(negedge clk);
      if (b < 3) mem_wdata = wb[b+1];
    end
    mem_read  = 1'b0;
    mem_write = 1'b0;
    check("resp_done_low", 64'(mem_resp), 64'd0);
  endtask

  task automatic check_line(input string tag, input logic [63:0] got [4],
                            input logic [63:0] exp [4]);
    for (int b = 0; b < 4; b++) check(tag, got[b], exp[b]);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] line_a [4];
    logic [63:0] zeros [4];
    logic [63:0] partial [4];
    logic [63:0] rb [4];
    int          first;
    int          k;
    logic        seen;

    line_a  = '{{16{4'h1}}, {16{4'h2}}, {16{4'h3}}, {16{4'h4}}};
    zeros   = '{64'd0, 64'd0, 64'd0, 64'd0};
    partial = '{{16{4'hA}}, {16{4'hA}}, 64'd0, 64'd0};

    rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0;
    mem_address = '0; mem_wdata = '0;
    repeat (3) @(negedge clk);
    check("rst_resp", 64'(mem_resp), 64'd0);
    check("rst_rdata", mem_rdata, 64'd0);
    check("rst_err", 64'(proto_err), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Write line 0x40 (WRITE_LATENCY=2) then read it back (READ_LATENCY=4).
    burst(1'b1, 32'h0000_0040, line_a, rb, first);
    check("wr_first", 64'(first), 64'd3);
    @(negedge clk);
    burst(1'b0, 32'h0000_0040, zeros, rb, first);
    check("rd_first", 64'(first), 64'd5);
    check_line("rd_0x40", rb, line_a);
    @(negedge clk);
    burst(1'b0, 32'h0000_005C, zeros, rb, first);
    check_line("rd_0x5c", rb, line_a);
    @(negedge clk);
    burst(1'b0, 32'h0000_2040, zeros, rb, first);
    check_line("rd_alias", rb, line_a);
    check("err_clean", 64'(proto_err), 64'd0);
`ifdef BURST_MEM_STATS_EN
    check("wr_lines_1", 64'(wr_lines), 64'd1);
    check("rd_lines_3", 64'(rd_lines), 64'd3);
`endif

    // Read dropped during latency: no beats, no error.
    @(negedge clk);
    mem_address = 32'h0000_0040;
    mem_read    = 1'b1;
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    mem_read = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); @(negedge clk);
      seen |= mem_resp | (|mem_rdata);
    end
    check("abort_no_resp", 64'(seen), 64'd0);
    check("abort_err", 64'(proto_err), 64'd0);
`ifdef BURST_MEM_STATS_EN
    check("abort_rd_lines", 64'(rd_lines), 64'd3);
`endif

    // Read and write together: read wins, sticky error.
    mem_write = 1'b1;
    burst(1'b0, 32'h0000_0040, zeros, rb, first);
    check("both_first", 64'(first), 64'd5);
    check_line("both_data", rb, line_a);
    check("both_err", 64'(proto_err), 64'd1);
    repeat (5) @(negedge clk);
    check("err_sticky", 64'(proto_err), 64'd1);

    // Zero line 0x80, then reset in the middle of an 0xAA write burst.
    burst(1'b1, 32'h0000_0080, zeros, rb, first);
    check("err_still", 64'(proto_err), 64'd1);
    @(negedge clk);
    mem_address = 32'h0000_0080;
    mem_wdata   = {16{4'hA}};
    mem_write   = 1'b1;
    k = 0;
    while (k < 40 && mem_resp !== 1'b1) begin
      @(posedge clk); k++; @(negedge clk);
    end
    check("aa_first", 64'(k), 64'd3);
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    check("aa_beat2_resp", 64'(mem_resp), 64'd1);
    rst = 1'b1;
    #1;
    check("midrst_resp", 64'(mem_resp), 64'd0);
    check("midrst_rdata", mem_rdata, 64'd0);
    check("midrst_err", 64'(proto_err), 64'd0);
`ifdef BURST_MEM_STATS_EN
    check("midrst_rd_lines", 64'(rd_lines), 64'd0);
`endif
    @(negedge clk);
    rst       = 1'b0;
    mem_write = 1'b0;
    @(negedge clk);

    // Back-to-back reads of the partial line; second request raised in the DONE cycle.
    burst(1'b0, 32'h0000_0080, zeros, rb, first);
    check("b2b_first0", 64'(first), 64'd5);
    check_line("partial_0", rb, partial);
    burst(1'b0, 32'h0000_0080, zeros, rb, first);
    check("b2b_first1", 64'(first), 64'd6);
    check_line("partial_1", rb, partial);
    check("b2b_err", 64'(proto_err), 64'd0);
`ifdef BURST_MEM_STATS_EN
    check("b2b_rd_lines", 64'(rd_lines), 64'd2);
    check("b2b_wr_lines", 64'(wr_lines), 64'd0);
`endif

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
